spec_shift: RTL and testbench

- Spectral-domain effect stage between the FFT IP output and the `hann` windowing/overlap-add block.
- Captures one N-bin forward-FFT frame while `hann` reports `fft_storing`.
- Once `fft_stored` rises, replays the frame as IFFT input on `freq_data`/`freq_valid`/`freq_last`, with a bin-offset frequency shift and a Q4.4 gain applied.
- Provides the voice-changer frequency-shift effect.

---
 rtl/voice_pkg.sv | 27 ++
 rtl/spec_ram.sv | 24 ++
 rtl/spec_shift.sv | 210 +++++++++++++++++++++
 tb/tb_spec_shift.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/voice_pkg.sv
// Shared voice-changer types, defaults and saturation helper.
// Holds FSM encodings, frame length default, Q4.4 unity gain and sat16.
package voice_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_CAPTURE = 2'd1,
      ST_WAIT    = 2'd2,
      ST_PLAY    = 2'd3
   } state_t;

   localparam int DEF_FRAME_LENTH = 1024;

   localparam logic [7:0] GAIN_UNITY = 8'h10;

   function automatic logic [15:0] sat16(input logic signed [31:0] v);
      logic [15:0] r;
      if (v > 32'sd32767)
         r = 16'h7fff;
      else if (v < -32'sd32768)
         r = 16'h8000;
      else
         r = v[15:0];
      return r;
   endfunction

endpackage

// File: rtl/spec_ram.sv
// Simple dual-port frame RAM, one write and one registered read port.
// Ports: clk, we/waddr/wdata write side, raddr in, rdata out (1-cycle).
module spec_ram #(
   parameter int DEPTH = 1024,
   parameter int AW    = 10,
   parameter int W     = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/spec_shift.sv
// Spectral frequency-shift stage: captures an FFT frame, replays it shifted.
// Ports: i_aclk/rst, FFT AXI-S in, hann handshakes, shift/gain, freq_* out.
module spec_shift
   import voice_pkg::*;
#(
   parameter int FRAME_LENTH = DEF_FRAME_LENTH,
   parameter int IN_SHIFT    = 9,
   parameter int SHIFT_W     = 6
) (
   input  logic                      i_aclk,
   input  logic                      rst,
   input  logic                      i_axi4s_data_tvalid,
   input  logic [63:0]               i_axi4s_data_tdata,
   input  logic                      i_axi4s_data_tlast,
   input  logic                      fft_storing,
   input  logic                      fft_stored,
   input  logic signed [SHIFT_W-1:0] shift_bins,
   input  logic [7:0]                gain,
   output logic [31:0]               freq_data,
   output logic                      freq_valid,
   output logic                      freq_last,
   output logic                      frame_err,
   output logic                      busy
);

   localparam int AW   = $clog2(FRAME_LENTH);
   localparam int HALF = FRAME_LENTH / 2;
   localparam int TW   = AW + 2;

   localparam logic [AW-1:0] LAST_A = AW'(FRAME_LENTH - 1);
   localparam logic [AW-1:0] HALF_A = AW'(HALF);

   localparam logic signed [TW-1:0] T_ONE  = TW'(1);
   localparam logic signed [TW-1:0] T_HM1  = TW'(HALF - 1);
   localparam logic signed [TW-1:0] T_HP1  = TW'(HALF + 1);
   localparam logic signed [TW-1:0] T_LAST = TW'(FRAME_LENTH - 1);

   state_t state_q, state_d;

   logic          stored_q;
   logic          rise;
   logic [AW-1:0] wr_addr;
   logic          beat;
   logic          at_end;
   logic          cap_done;
   logic [31:0]   wr_data;

   assign rise     = fft_stored & ~stored_q;
   assign beat     = (state_q == ST_CAPTURE) && i_axi4s_data_tvalid;
   assign at_end   = (wr_addr == LAST_A);
   assign cap_done = beat && (i_axi4s_data_tlast || at_end);
   assign busy     = (state_q != ST_IDLE);

   assign wr_data = {
      sat16($signed(i_axi4s_data_tdata[63:32]) >>> IN_SHIFT),
      sat16($signed(i_axi4s_data_tdata[31:0]) >>> IN_SHIFT)
   };

   always_ff @(posedge i_aclk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE:    if (fft_storing) state_d = ST_CAPTURE;
         ST_CAPTURE: if (cap_done || !fft_storing) state_d = ST_WAIT;
         ST_WAIT:    if (rise) state_d = ST_PLAY;
         ST_PLAY:    if (freq_last) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // Capture side: address counter and sticky frame-length error.
   always_ff @(posedge i_aclk) begin
      if (rst) begin
         stored_q  <= 1'b0;
         wr_addr   <= '0;
         frame_err <= 1'b0;
      end else begin
         stored_q <= fft_stored;
         if (state_q == ST_IDLE && fft_storing) begin
            wr_addr   <= '0;
            frame_err <= 1'b0;
         end else if (beat) begin
            wr_addr <= wr_addr + 1'b1;
            if (i_axi4s_data_tlast != at_end)
               frame_err <= 1'b1;
         end
      end
   end

   // Replay side
   logic [AW:0]               k_q;
   logic signed [SHIFT_W-1:0] shift_q;
   logic [7:0]                gain_q;
   logic                      issue;
   logic [AW-1:0]             kk;

   assign issue = (state_q == ST_PLAY) && !k_q[AW];
   assign kk    = k_q[AW-1:0];

   logic signed [TW-1:0] ks, ss, t;
   logic [AW-1:0]        src_d;
   logic                 zero_d;

   assign ks = $signed({2'b00, kk});
   assign ss = {{(TW - SHIFT_W){shift_q[SHIFT_W-1]}}, shift_q};

   // Lower and upper halves move in opposite directions so the
   // shifted spectrum keeps conjugate symmetry.
   always_comb begin
      src_d  = kk;
      zero_d = 1'b0;
      t      = '0;
      if (kk == '0) begin
         src_d = '0;
      end else if (kk < HALF_A) begin
         t      = ks - ss;
         src_d  = t[AW-1:0];
         zero_d = (t < T_ONE) || (t > T_HM1);
      end else if (kk == HALF_A) begin
         zero_d = (shift_q != '0);
      end else begin
         t      = ks + ss;
         src_d  = t[AW-1:0];
         zero_d = (t < T_HP1) || (t > T_LAST);
      end
   end

   logic [AW-1:0] s0_src;
   logic          s0_v, s0_zero, s0_last;
   logic          s1_v, s1_zero, s1_last;
   logic          s2_v, s2_last;
   logic [31:0]   ram_q;
   logic [31:0]   sel;
   logic signed [23:0] m_re, m_im;
   logic signed [23:0] p_re, p_im;
   logic signed [23:0] q_re, q_im;

   assign sel  = s1_zero ? 32'h0 : ram_q;
   assign m_re = $signed({{8{sel[15]}}, sel[15:0]})
               * $signed({16'h0, gain_q});
   assign m_im = $signed({{8{sel[31]}}, sel[31:16]})
               * $signed({16'h0, gain_q});
   assign q_re = p_re >>> 4;
   assign q_im = p_im >>> 4;

   always_ff @(posedge i_aclk) begin
      if (rst) begin
         k_q        <= '0;
         shift_q    <= '0;
         gain_q     <= '0;
         s0_src     <= '0;
         s0_v       <= 1'b0;
         s0_zero    <= 1'b0;
         s0_last    <= 1'b0;
         s1_v       <= 1'b0;
         s1_zero    <= 1'b0;
         s1_last    <= 1'b0;
         s2_v       <= 1'b0;
         s2_last    <= 1'b0;
         p_re       <= '0;
         p_im       <= '0;
         freq_data  <= '0;
         freq_valid <= 1'b0;
         freq_last  <= 1'b0;
      end else begin
         if (state_q == ST_WAIT && rise) begin
            k_q     <= '0;
            shift_q <= shift_bins;
            gain_q  <= gain;
         end else if (issue) begin
            k_q <= k_q + 1'b1;
         end
         s0_src     <= src_d;
         s0_v       <= issue;
         s0_zero    <= zero_d;
         s0_last    <= issue && (kk == LAST_A);
         s1_v       <= s0_v;
         s1_zero    <= s0_zero;
         s1_last    <= s0_last;
         p_re       <= m_re;
         p_im       <= m_im;
         s2_v       <= s1_v;
         s2_last    <= s1_last;
         freq_data  <= {sat16({{8{q_im[23]}}, q_im}),
                        sat16({{8{q_re[23]}}, q_re})};
         freq_valid <= s2_v;
         freq_last  <= s2_last;
      end
   end

   spec_ram #(
      .DEPTH (FRAME_LENTH),
      .AW    (AW),
      .W     (32)
   ) u_ram (
      .clk   (i_aclk),
      .we    (beat),
      .waddr (wr_addr),
      .wdata (wr_data),
      .raddr (s0_src),
      .rdata (ram_q)
   );

endmodule

// File: tb/tb_spec_shift.sv
// Self-checking bench for spec_shift with a frame-level reference model.
// Drives capture frames and replays, compares every replayed bin.
module tb_spec_shift;

   localparam int N  = 1024;
   localparam int IS = 9;
   localparam int SW = 6;

   logic                 clk = 1'b0;
   logic                 rst;
   logic                 tvalid;
   logic [63:0]          tdata;
   logic                 tlast;
   logic                 storing;
   logic                 stored;
   logic signed [SW-1:0] shift_bins;
   logic [7:0]           gain;
   logic [31:0]          freq_data;
   logic                 freq_valid;
   logic                 freq_last;
   logic                 frame_err;
   logic                 busy;

   always #5 clk = ~clk;

   spec_shift #(
      .FRAME_LENTH (N),
      .IN_SHIFT    (IS),
      .SHIFT_W     (SW)
   ) dut (
      .i_aclk              (clk),
      .rst                 (rst),
      .i_axi4s_data_tvalid (tvalid),
      .i_axi4s_data_tdata  (tdata),
      .i_axi4s_data_tlast  (tlast),
      .fft_storing         (storing),
      .fft_stored          (stored),
      .shift_bins          (shift_bins),
      .gain                (gain),
      .freq_data           (freq_data),
      .freq_valid          (freq_valid),
      .freq_last           (freq_last),
      .frame_err           (frame_err),
      .busy                (busy)
   );

   int nvec = 0;
   int nerr = 0;

   int          m_re [N];
   int          m_im [N];
   bit          m_err;
   logic [63:0] fr   [N+8];
   logic [31:0] got  [N];

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int ingest(input logic [31:0] c);
      int v;
      v = int'($signed(c));
      return clamp16(v >>> IS);
   endfunction

   function automatic int scale(input int c, input int g);
      return clamp16((c * g) >>> 4);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      nvec++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic capture(input int nb, input int tl_at);
      int addr;
      bit act;
      bit tl;
      addr  = 0;
      act   = 1'b1;
      m_err = 1'b0;
      @(negedge clk);
      storing = 1'b1;
      @(posedge clk);
      for (int i = 0; i < nb; i++) begin
         @(negedge clk);
         tl     = (i == tl_at);
         tvalid = 1'b1;
         tdata  = fr[i];
         tlast  = tl;
         if (act) begin
            m_re[addr] = ingest(fr[i][31:0]);
            m_im[addr] = ingest(fr[i][63:32]);
            m_err = (tl != (addr == N - 1));
            if (tl || addr == N - 1) act = 1'b0;
            addr++;
         end
      end
      @(negedge clk);
      tvalid  = 1'b0;
      tlast   = 1'b0;
      storing = 1'b0;
      @(negedge clk);
      check("cap_busy", busy, 1);
      check("frame_err", frame_err, m_err);
   endtask

   task automatic play(input int sh, input int gn, input int abort_at);
      int lat;
      int src;
      bit z;
      int er;
      int ei;
      @(negedge clk);
      shift_bins = SW'(sh);
      gain       = 8'(gn);
      stored     = 1'b1;
      @(negedge clk);
      shift_bins = SW'($urandom);
      gain       = 8'($urandom);
      lat = 1;
      while (!freq_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, 5);
      for (int k = 0; k < N; k++) begin
         if (k > 0) @(negedge clk);
         src = k;
         z   = 1'b0;
         if (k == 0) begin
            src = 0;
         end else if (k < N / 2) begin
            src = k - sh;
            z   = (src < 1) || (src > N / 2 - 1);
         end else if (k == N / 2) begin
            z = (sh != 0);
         end else begin
            src = k + sh;
            z   = (src < N / 2 + 1) || (src > N - 1);
         end
         er = z ? 0 : scale(m_re[src], gn);
         ei = z ? 0 : scale(m_im[src], gn);
         got[k] = freq_data;
         check($sformatf("beat%0d", k),
               {freq_valid, freq_last, freq_data},
               {1'b1, k == N - 1, 16'(ei), 16'(er)});
         if (k == abort_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst    = 1'b0;
            stored = 1'b0;
            check("abort_valid", freq_valid, 0);
            check("abort_busy", busy, 0);
            return;
         end
      end
      @(negedge clk);
      check("end_valid", {freq_valid, freq_last}, 0);
      check("end_busy", busy, 0);
      stored = 1'b0;
   endtask

   task automatic fill_ramp();
      for (int i = 0; i < N + 8; i++)
         fr[i] = {32'h0, 32'(i << IS)};
   endtask

   task automatic fill_rand();
      int v;
      int w;
      for (int i = 0; i < N + 8; i++) begin
         v = int'($urandom) >>> $urandom_range(0, 14);
         w = int'($urandom) >>> $urandom_range(0, 14);
         fr[i] = {32'(w), 32'(v)};
      end
   endtask

   initial begin
      int seen;
      rst        = 1'b1;
      tvalid     = 1'b0;
      tdata      = '0;
      tlast      = 1'b0;
      storing    = 1'b0;
      stored     = 1'b0;
      shift_bins = '0;
      gain       = 8'h10;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_valid", freq_valid, 0);
      check("rst_last", freq_last, 0);
      check("rst_data", freq_data, 0);
      check("rst_err", frame_err, 0);
      check("rst_busy", busy, 0);

      // ramp frame, unity replay
      fill_ramp();
      capture(N, N - 1);
      play(0, 16, -1);
      check("ramp_0", got[0], 32'd0);
      check("ramp_1023", got[1023], 32'd1023);

      // same frame shifted up by 3 bins
      capture(N, N - 1);
      play(3, 16, -1);
      check("sh_b1", got[1], 0);
      check("sh_b3", got[3], 0);
      check("sh_b4", got[4], 32'd1);
      check("sh_b511", got[511], 32'd508);
      check("sh_b512", got[512], 0);
      check("sh_b1020", got[1020], 32'd1023);
      check("sh_b1021", got[1021], 0);
      check("sh_b1023", got[1023], 0);

      // gain and input saturation corners
      fill_rand();
      fr[5] = {32'h0, 32'(20000 << IS)};
      fr[6] = {32'h0, 32'(-100 * 512)};
      fr[7] = {32'h0, 32'h7fff_ffff};
      fr[8] = {32'h8000_0000, 32'h8000_0000};
      capture(N, N - 1);
      play(0, 8'h20, -1);
      check("gain2_sat", got[5][15:0], 16'h7fff);
      capture(N, N - 1);
      play(0, 8'h08, -1);
      check("gain_half_neg", got[6][15:0], 16'hffce);
      capture(N, N - 1);
      play(0, 8'h10, -1);
      check("in_sat_pos", got[7][15:0], 16'h7fff);
      check("in_sat_neg", got[8], 32'h8000_8000);

      // random shifts and gains
      for (int r = 0; r < 3; r++) begin
         fill_rand();
         capture(N, N - 1);
         play($urandom_range(0, 62) - 31, $urandom_range(0, 255), -1);
      end

      // short frame, recovery, overlong frame
      fill_rand();
      capture(N, 500);
      check("short_err", frame_err, 1);
      play(-5, 8'h10, -1);
      fill_rand();
      capture(N, N - 1);
      check("full_clr", frame_err, 0);
      play(0, 8'h10, -1);
      fill_rand();
      capture(N + 6, -1);
      check("long_err", frame_err, 1);
      play(0, 8'h10, -1);

      // reset mid-replay, then an orphan fft_stored rise
      fill_rand();
      capture(N, N - 1);
      play(2, 8'h10, 300);
      @(negedge clk);
      stored = 1'b1;
      seen   = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (freq_valid || busy) seen++;
      end
      stored = 1'b0;
      check("orphan_rise", seen, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
